// File: rtl/rx_ant_div_select.sv
// Receive-diversity antenna selector: per-antenna RSSI IIR smoothing, hysteretic
// best-antenna choice with dwell time, packet lock and manual force, plus IQ mux.
module rx_ant_div_select #(
   parameter int NUM_ANT   = 4,
   parameter int SEL_W     = 2,
   parameter int RSSI_W    = 11,
   parameter int SAMPLE_W  = 32,
   parameter int AVG_SHIFT = 2,
   parameter int HYST      = 6,
   parameter int HOLD_SMP  = 16
) (
   input  logic                        clock,
   input  logic                        rstn,
   input  logic                        enable,
   input  logic [NUM_ANT*RSSI_W-1:0]   rssi_half_db,
   input  logic [NUM_ANT*SAMPLE_W-1:0] sample_in,
   input  logic                        sample_in_strobe,
   input  logic                        pkt_lock,
   input  logic                        force_en,
   input  logic [SEL_W-1:0]            force_ant,
   output logic [SAMPLE_W-1:0]         sample_out,
   output logic                        sample_out_strobe,
   output logic [SEL_W-1:0]            ant_select,
   output logic                        switch_strobe,
   output logic [RSSI_W-1:0]           rssi_sel,
   output logic [1:0]                  state
);

   localparam int ACC_W = RSSI_W + AVG_SHIFT;
   localparam int CNT_W = (HOLD_SMP > 1) ? $clog2(HOLD_SMP) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_SMP - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_HOLD   = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    hold_q, hold_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic                force_q;
   logic                first_q;
   logic [SAMPLE_W-1:0] sout_q;
   logic                sostb_q;
   logic                sw_q;
   logic [ACC_W-1:0]    acc_q [NUM_ANT];
   logic [ACC_W-1:0]    acc_d [NUM_ANT];
   logic [RSSI_W-1:0]   avg_d [NUM_ANT];
   logic [RSSI_W-1:0]   rssi  [NUM_ANT];
   logic [SAMPLE_W-1:0] smp   [NUM_ANT];

   logic                strobe_cyc;
   logic [SEL_W-1:0]    best_idx;
   logic [RSSI_W-1:0]   best_avg;
   logic [RSSI_W-1:0]   cur_avg;
   logic                sw_pass;
   logic                force_ok;
   logic                force_fall;
   logic [ACC_W-1:0]    sel_acc;

   assign strobe_cyc = enable & sample_in_strobe;
   assign force_fall = force_q & ~force_en;
   assign force_ok   = force_en && ({1'b0, force_ant} < (SEL_W+1)'(NUM_ANT));

   // The first strobe preloads the accumulator so the average starts at the live level.
   always_comb begin
      for (int k = 0; k < NUM_ANT; k++) begin
         rssi[k] = rssi_half_db[k*RSSI_W +: RSSI_W];
         smp[k]  = sample_in[k*SAMPLE_W +: SAMPLE_W];
         acc_d[k] = acc_q[k];
         if (strobe_cyc) begin
            if (first_q) acc_d[k] = ACC_W'(rssi[k]) << AVG_SHIFT;
            else         acc_d[k] = acc_q[k] - (acc_q[k] >> AVG_SHIFT) + ACC_W'(rssi[k]);
         end
         avg_d[k] = acc_d[k][ACC_W-1:AVG_SHIFT];
      end
   end

   // Strict ">" keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_avg = avg_d[0];
      for (int k = 1; k < NUM_ANT; k++) begin
         if (avg_d[k] > best_avg) begin
            best_idx = SEL_W'(k);
            best_avg = avg_d[k];
         end
      end
      cur_avg = avg_d[sel_q];
      sw_pass = ({1'b0, best_avg} > ({1'b0, cur_avg} + (RSSI_W+1)'(HYST)));
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      sel_d   = sel_q;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_SEARCH;
            ST_LOCKED: begin
               if (!pkt_lock) begin
                  state_d = ST_HOLD;
                  hold_d  = HOLD_LOAD;
               end
            end
            default: begin
               if (strobe_cyc && pkt_lock) begin
                  state_d = ST_LOCKED;
               end else if (force_fall) begin
                  state_d = ST_HOLD;
                  hold_d  = HOLD_LOAD;
               end else if (strobe_cyc) begin
                  if (state_q == ST_SEARCH) begin
                     if (!force_en && sw_pass) begin
                        sel_d   = best_idx;
                        hold_d  = HOLD_LOAD;
                        state_d = ST_HOLD;
                     end
                  end else if (hold_q <= CNT_W'(1)) begin
                     hold_d  = '0;
                     state_d = ST_SEARCH;
                  end else begin
                     hold_d = hold_q - CNT_W'(1);
                  end
               end
            end
         endcase
         if (strobe_cyc && (state_q != ST_IDLE) && force_ok) sel_d = force_ant;
      end
   end

   // NOTE: the accumulators are a small register array, not RAM, so clearing them in reset is fine.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         sel_q   <= '0;
         force_q <= 1'b0;
         first_q <= 1'b1;
         sout_q  <= '0;
         sostb_q <= 1'b0;
         sw_q    <= 1'b0;
         for (int k = 0; k < NUM_ANT; k++) acc_q[k] <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         sel_q   <= sel_d;
         force_q <= force_en;
         sostb_q <= strobe_cyc;
         sw_q    <= (sel_d != sel_q);
         if (strobe_cyc) begin
            first_q <= 1'b0;
            sout_q  <= smp[sel_q];
         end
         for (int k = 0; k < NUM_ANT; k++) acc_q[k] <= acc_d[k];
      end
   end

   assign sel_acc           = acc_q[sel_q];
   assign sample_out        = sout_q;
   assign sample_out_strobe = sostb_q;
   assign ant_select        = sel_q;
   assign switch_strobe     = sw_q;
   assign rssi_sel          = sel_acc[ACC_W-1:AVG_SHIFT];
   assign state             = state_q;

endmodule

// File: tb/tb_rx_ant_div_select.sv
// Bench for rx_ant_div_select: hand vectors, multi-cycle corner sequences and a
// randomized run compared every cycle with a behavioural model.
module tb_rx_ant_div_select;

   localparam int NUM_ANT   = 4;
   localparam int SEL_W     = 2;
   localparam int RSSI_W    = 11;
   localparam int SAMPLE_W  = 32;
   localparam int AVG_SHIFT = 2;
   localparam int HYST      = 6;
   localparam int HOLD_SMP  = 16;
   localparam int S_IDLE = 0, S_SEARCH = 1, S_HOLD = 2, S_LOCKED = 3;

   logic                        clock;
   logic                        rstn;
   logic                        enable;
   logic [NUM_ANT*RSSI_W-1:0]   rssi_half_db;
   logic [NUM_ANT*SAMPLE_W-1:0] sample_in;
   logic                        sample_in_strobe;
   logic                        pkt_lock;
   logic                        force_en;
   logic [SEL_W-1:0]            force_ant;
   logic [SAMPLE_W-1:0]         sample_out;
   logic                        sample_out_strobe;
   logic [SEL_W-1:0]            ant_select;
   logic                        switch_strobe;
   logic [RSSI_W-1:0]           rssi_sel;
   logic [1:0]                  state;

   rx_ant_div_select #(
      .NUM_ANT(NUM_ANT), .SEL_W(SEL_W), .RSSI_W(RSSI_W), .SAMPLE_W(SAMPLE_W),
      .AVG_SHIFT(AVG_SHIFT), .HYST(HYST), .HOLD_SMP(HOLD_SMP)
   ) dut (
      .clock(clock), .rstn(rstn), .enable(enable), .rssi_half_db(rssi_half_db),
      .sample_in(sample_in), .sample_in_strobe(sample_in_strobe), .pkt_lock(pkt_lock),
      .force_en(force_en), .force_ant(force_ant), .sample_out(sample_out),
      .sample_out_strobe(sample_out_strobe), .ant_select(ant_select),
      .switch_strobe(switch_strobe), .rssi_sel(rssi_sel), .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural reference model, one call per clock edge.
   int            m_acc [NUM_ANT];
   bit            m_first;
   int            m_sel, m_state, m_hold;
   bit            m_force_prev, m_sw, m_sostb;
   logic [31:0]   m_sout;

   function automatic int m_avg(input int k);
      return m_acc[k] / (1 << AVG_SHIFT);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NUM_ANT; k++) m_acc[k] = 0;
      m_first = 1; m_sel = 0; m_state = S_IDLE; m_hold = 0;
      m_force_prev = 0; m_sw = 0; m_sostb = 0; m_sout = '0;
   endtask

   task automatic model_step();
      bit sc;
      int old_sel, best, prev_state, r;
      sc = enable && sample_in_strobe;
      old_sel = m_sel;
      prev_state = m_state;
      m_sostb = sc;
      if (sc) begin
         m_sout = sample_in[old_sel*SAMPLE_W +: SAMPLE_W];
         for (int k = 0; k < NUM_ANT; k++) begin
            r = int'(rssi_half_db[k*RSSI_W +: RSSI_W]);
            if (m_first) m_acc[k] = r * (1 << AVG_SHIFT);
            else         m_acc[k] = m_acc[k] - m_avg(k) + r;
         end
         m_first = 0;
      end
      best = 0;
      for (int k = 1; k < NUM_ANT; k++) if (m_avg(k) > m_avg(best)) best = k;
      if (!enable) m_state = S_IDLE;
      else if (m_state == S_IDLE) m_state = S_SEARCH;
      else if (m_state == S_LOCKED) begin
         if (!pkt_lock) begin m_state = S_HOLD; m_hold = HOLD_SMP - 1; end
      end else if (sc && pkt_lock) m_state = S_LOCKED;
      else if (m_force_prev && !force_en) begin m_state = S_HOLD; m_hold = HOLD_SMP - 1; end
      else if (sc) begin
         if (m_state == S_SEARCH) begin
            if (!force_en && m_avg(best) > m_avg(old_sel) + HYST) begin
               m_sel = best; m_hold = HOLD_SMP - 1; m_state = S_HOLD;
            end
         end else if (m_hold <= 1) begin
            m_hold = 0; m_state = S_SEARCH;
         end else m_hold--;
      end
      if (sc && prev_state != S_IDLE && force_en && int'(force_ant) < NUM_ANT) m_sel = int'(force_ant);
      m_sw = (m_sel != old_sel);
      m_force_prev = force_en;
   endtask

   logic [63:0]                 got_all, exp_all;
   logic [NUM_ANT*SAMPLE_W-1:0] last_smp;
   bit                          last_sw;
   int                          n_sw;
   int                          strobe_idx;

   task automatic cyc(input bit stb);
      sample_in_strobe = stb;
      sample_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (stb) last_smp = sample_in;
      model_step();
      @(posedge clock);
      #1;
      got_all = {15'd0, sample_out, sample_out_strobe, ant_select, switch_strobe, rssi_sel, state};
      exp_all = {15'd0, m_sout, m_sostb, SEL_W'(m_sel), m_sw, RSSI_W'(m_avg(m_sel)), 2'(m_state)};
      check("cycle_vs_model", got_all, exp_all);
      sample_in_strobe = 1'b0;
   endtask

   task automatic strobe(input int gap);
      cyc(1'b1);
      last_sw = switch_strobe;
      if (switch_strobe) n_sw++;
      strobe_idx++;
      repeat (gap) cyc(1'b0);
   endtask

   task automatic set_rssi(input int r0, input int r1, input int r2, input int r3);
      rssi_half_db = {RSSI_W'(r3), RSSI_W'(r2), RSSI_W'(r1), RSSI_W'(r0)};
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      rstn = 1'b1;
      n_sw = 0;
      strobe_idx = 0;
   endtask

   // Starts a scenario: reset, enable, one idle cycle to leave IDLE.
   task automatic start(input int r0, input int r1, input int r2, input int r3);
      enable = 1'b0; pkt_lock = 1'b0; force_en = 1'b0; force_ant = '0;
      set_rssi(r0, r1, r2, r3);
      do_reset();
      enable = 1'b1;
      cyc(1'b0);
   endtask

   typedef struct {
      int r0, r1, r2, r3;
      bit lock, fen;
      int fant;
      int exp_sel;
      bit exp_sw;
      int exp_st;
   } vec_t;

   vec_t tbl [8];
   int   sw_times [$];
   int   min_gap;
   int   rv [NUM_ANT];

   initial begin
      tbl[0] = '{50, 100, 50,  50, 1'b0, 1'b0, 0, 1, 1'b1, S_HOLD};
      tbl[1] = '{50, 100, 50,  50, 1'b0, 1'b0, 0, 1, 1'b0, S_HOLD};
      tbl[2] = '{50, 100, 50,  50, 1'b1, 1'b0, 0, 1, 1'b0, S_LOCKED};
      tbl[3] = '{50, 100, 200, 50, 1'b1, 1'b0, 0, 1, 1'b0, S_LOCKED};
      tbl[4] = '{50, 100, 200, 50, 1'b1, 1'b1, 3, 3, 1'b1, S_LOCKED};
      tbl[5] = '{50, 100, 200, 50, 1'b1, 1'b1, 3, 3, 1'b0, S_LOCKED};
      tbl[6] = '{50, 100, 200, 50, 1'b0, 1'b1, 0, 0, 1'b1, S_HOLD};
      tbl[7] = '{50, 100, 200, 50, 1'b0, 1'b0, 0, 0, 1'b0, S_HOLD};

      rstn = 1'b0; enable = 1'b0; pkt_lock = 1'b0; force_en = 1'b0; force_ant = '0;
      sample_in_strobe = 1'b0; sample_in = '0; set_rssi(0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_outputs", {sample_out, sample_out_strobe, ant_select, switch_strobe, rssi_sel, state}, 64'd0);
      rstn = 1'b1;

      // Table: steady selection, lock, force during lock, lock fall and force fall.
      start(50, 100, 50, 50);
      for (int i = 0; i < 8; i++) begin
         set_rssi(tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].r3);
         pkt_lock  = tbl[i].lock;
         force_en  = tbl[i].fen;
         force_ant = SEL_W'(tbl[i].fant);
         strobe(0);
         check($sformatf("tbl%0d_sel", i), 64'(ant_select), 64'(tbl[i].exp_sel));
         check($sformatf("tbl%0d_sw", i), 64'(switch_strobe), 64'(tbl[i].exp_sw));
         check($sformatf("tbl%0d_state", i), 64'(state), 64'(tbl[i].exp_st));
         if (i == 1) check("tbl_sample_ant1", 64'(sample_out), 64'(last_smp[SAMPLE_W +: SAMPLE_W]));
         repeat (3) cyc(1'b0);
      end

      // Hysteresis: a 5 half-dB lead never switches; 7 switches once the IIR reaches 107.
      start(100, 100, 0, 0);
      strobe(3);
      set_rssi(100, 105, 0, 0);
      repeat (30) strobe(3);
      check("hyst_no_switch_sel", 64'(ant_select), 64'd0);
      check("hyst_no_switch_cnt", 64'(n_sw), 64'd0);
      set_rssi(100, 107, 0, 0);
      repeat (5) strobe(3);
      check("hyst_before_settle", 64'(ant_select), 64'd0);
      strobe(3);
      check("hyst_switch_sel", 64'(ant_select), 64'd1);
      check("hyst_switch_sw", 64'(last_sw), 64'd1);

      // Dwell: best antenna alternates every 4 strobes with a 20 dB gap.
      start(120, 80, 0, 0);
      sw_times.delete();
      for (int i = 0; i < 96; i++) begin
         if ((i / 4) % 2 == 0) set_rssi(120, 80, 0, 0);
         else                  set_rssi(80, 120, 0, 0);
         strobe(2);
         if (last_sw) sw_times.push_back(i);
      end
      min_gap = 1000;
      for (int i = 1; i < sw_times.size(); i++)
         if (sw_times[i] - sw_times[i-1] < min_gap) min_gap = sw_times[i] - sw_times[i-1];
      check("dwell_min_gap_ok", 64'(min_gap >= HOLD_SMP), 64'd1);
      check("dwell_some_switches", 64'(sw_times.size() >= 2), 64'd1);

      // Lock: a much stronger antenna is ignored until 16 strobes after the lock falls.
      start(100, 100, 100, 100);
      strobe(3);
      pkt_lock = 1'b1;
      set_rssi(100, 200, 100, 100);
      repeat (20) strobe(3);
      check("lock_sel_held", 64'(ant_select), 64'd0);
      check("lock_state", 64'(state), 64'(S_LOCKED));
      check("lock_no_switch", 64'(n_sw), 64'd0);
      pkt_lock = 1'b0;
      cyc(1'b0);
      check("lock_fall_hold", 64'(state), 64'(S_HOLD));
      repeat (15) strobe(3);
      check("lock_15th_sel", 64'(ant_select), 64'd0);
      check("lock_15th_state", 64'(state), 64'(S_SEARCH));
      strobe(3);
      check("lock_16th_sel", 64'(ant_select), 64'd1);
      check("lock_16th_sw", 64'(last_sw), 64'd1);

      // Ties then an asynchronous reset pulse mid-stream.
      start(77, 77, 77, 77);
      repeat (20) strobe(3);
      check("tie_sel", 64'(ant_select), 64'd0);
      check("tie_no_switch", 64'(n_sw), 64'd0);
      set_rssi(10, 300, 10, 10);
      repeat (3) strobe(3);
      rstn = 1'b0;
      #1;
      check("async_reset_outputs", {sample_out, sample_out_strobe, ant_select, switch_strobe, rssi_sel, state}, 64'd0);
      #2;
      rstn = 1'b1;
      model_reset();
      n_sw = 0;

      // Randomized traffic against the model.
      for (int k = 0; k < NUM_ANT; k++) rv[k] = $urandom_range(2047);
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(199) == 0) enable = ~enable;
         if ($urandom_range(59) == 0)  pkt_lock = ~pkt_lock;
         if ($urandom_range(149) == 0) force_en = ~force_en;
         if ($urandom_range(29) == 0)  force_ant = SEL_W'($urandom_range(NUM_ANT - 1));
         if ($urandom_range(3) == 0) begin
            for (int k = 0; k < NUM_ANT; k++) begin
               if ($urandom_range(49) == 0) rv[k] = $urandom_range(2047);
               else rv[k] = rv[k] + $urandom_range(40) - 20;
               if (rv[k] < 0) rv[k] = 0;
               if (rv[k] > 2047) rv[k] = 2047;
            end
            set_rssi(rv[0], rv[1], rv[2], rv[3]);
            cyc(1'b1);
         end else begin
            cyc(1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
